// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline status inputs and register-control outputs of pipe_hazard_ctrl
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       d_rs;
    logic [2:0]       d_rt;
    logic             d_rs_vld;
    logic             d_rt_vld;
    logic [2:0]       dx_rd;
    logic             dx_wen;
    logic             dx_load;
    logic [2:0]       xm_rd;
    logic             xm_wen;
    logic             xm_mem;
    logic             dmem_done;
    logic             imem_stall;
    logic             x_redirect;
    logic             dx_halt;

    logic             pc_en;
    logic             fd_en;
    logic             dx_en;
    logic             xm_en;
    logic             mw_en;
    logic             fd_nop;
    logic             dx_nop;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  d_rs, d_rt, d_rs_vld, d_rt_vld,
        input  dx_rd, dx_wen, dx_load,
        input  xm_rd, xm_wen, xm_mem, dmem_done,
        input  imem_stall, x_redirect, dx_halt,
        output pc_en, fd_en, dx_en, xm_en, mw_en,
        output fd_nop, dx_nop, halted, stall_cnt
    );

    modport slave (
        output d_rs, d_rt, d_rs_vld, d_rt_vld,
        output dx_rd, dx_wen, dx_load,
        output xm_rd, xm_wen, xm_mem, dmem_done,
        output imem_stall, x_redirect, dx_halt,
        input  pc_en, fd_en, dx_en, xm_en, mw_en,
        input  fd_nop, dx_nop, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline hazard/stall/halt sequencer; PIPE_FORWARD_EN enables forwarding-aware hazard rules
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_hazard_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        MWAIT  = 3'd1,
        DRAIN1 = 3'd2,
        DRAIN2 = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic fd_nop;
    logic dx_nop;
    logic halted;

    logic live;
    logic mem_freeze;
    logic src_hit_x;
    logic hazard;

    assign src_hit_x = (bus.d_rs_vld && (bus.d_rs == bus.dx_rd)) ||
                       (bus.d_rt_vld && (bus.d_rt == bus.dx_rd));

`ifdef PIPE_FORWARD_EN
    // X->D and M->D forwarding covers everything except a load still in X
    logic unused_fwd;
    assign unused_fwd = ^{bus.xm_rd, bus.xm_wen};
    assign hazard     = src_hit_x && bus.dx_wen && bus.dx_load;
`else
    // No forwarding: wait until the producer has left M (regfile writes before read in W)
    logic src_hit_m;
    assign src_hit_m = (bus.d_rs_vld && (bus.d_rs == bus.xm_rd)) ||
                       (bus.d_rt_vld && (bus.d_rt == bus.xm_rd));
    assign hazard    = (src_hit_x && bus.dx_wen) || (src_hit_m && bus.xm_wen);
`endif

    assign live       = (state == RUN) || (state == MWAIT);
    assign mem_freeze = ((state == RUN)   && bus.xm_mem && !bus.dmem_done) ||
                        ((state == MWAIT) && !bus.dmem_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // MWAIT releasing on dmem_done behaves like RUN for the rest of the rules
    always_comb begin
        state_nxt = state;
        case (state)
            RUN, MWAIT: begin
                if (mem_freeze) begin
                    state_nxt = MWAIT;
                end else if (bus.dx_halt) begin
                    state_nxt = DRAIN1;
                end else begin
                    state_nxt = RUN;
                end
            end
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en  = 1'b1;
        fd_en  = 1'b1;
        dx_en  = 1'b1;
        xm_en  = 1'b1;
        mw_en  = 1'b1;
        fd_nop = 1'b0;
        dx_nop = 1'b0;
        halted = 1'b0;
        if (live) begin
            if (mem_freeze) begin
                pc_en = 1'b0;
                fd_en = 1'b0;
                dx_en = 1'b0;
                xm_en = 1'b0;
                mw_en = 1'b0;
            end else if (bus.dx_halt) begin
                pc_en  = 1'b0;
                fd_nop = 1'b1;
                dx_nop = 1'b1;
            end else if (bus.x_redirect) begin
                fd_nop = 1'b1;
                dx_nop = 1'b1;
            end else if (hazard) begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                dx_nop = 1'b1;
            end else if (bus.imem_stall) begin
                pc_en  = 1'b0;
                fd_nop = 1'b1;
            end
        end else if ((state == DRAIN1) || (state == DRAIN2)) begin
            // Let X/M/W retire while nothing new enters D or X
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_nop = 1'b1;
        end else begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_en  = 1'b0;
            mw_en  = 1'b0;
            halted = (state == HALTED);
        end
        if (!rst) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_en  = 1'b0;
            mw_en  = 1'b0;
            fd_nop = 1'b0;
            dx_nop = 1'b0;
            halted = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (state != HALTED) && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.pc_en     = pc_en;
    assign bus.fd_en     = fd_en;
    assign bus.dx_en     = dx_en;
    assign bus.xm_en     = xm_en;
    assign bus.mw_en     = mw_en;
    assign bus.fd_nop    = fd_nop;
    assign bus.dx_nop    = dx_nop;
    assign bus.halted    = halted;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed plus randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipe_hazard_ctrl #(.CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int total  = 0;
    int passed = 0;

    // Reference: memory-wait flag, drain countdown, halted flag, counter as plain integers
    bit m_wait;
    bit m_halted;
    int m_drain;
    int m_cnt;

    logic [7:0] obs_out;
    assign obs_out = {bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
                      bus.fd_nop, bus.dx_nop, bus.halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic reads(input logic [2:0] r);
        return (bus.d_rs_vld && bus.d_rs == r) || (bus.d_rt_vld && bus.d_rt == r);
    endfunction

    function automatic logic model_hazard();
`ifdef PIPE_FORWARD_EN
        return bus.dx_wen && bus.dx_load && reads(bus.dx_rd);
`else
        return (bus.dx_wen && reads(bus.dx_rd)) || (bus.xm_wen && reads(bus.xm_rd));
`endif
    endfunction

    function automatic logic model_freeze();
        return (m_drain == 0) && !m_halted && !bus.dmem_done && (m_wait || bus.xm_mem);
    endfunction

    // {pc_en, fd_en, dx_en, xm_en, mw_en, fd_nop, dx_nop, halted}
    function automatic logic [7:0] model_out();
        if (m_halted)              return 8'b0000_0001;
        if (m_drain > 0)           return 8'b0011_1010;
        if (model_freeze())        return 8'b0000_0000;
        if (bus.dx_halt)           return 8'b0111_1110;
        if (bus.x_redirect)        return 8'b1111_1110;
        if (model_hazard())        return 8'b0011_1010;
        if (bus.imem_stall)        return 8'b0111_1100;
        return 8'b1111_1000;
    endfunction

    task automatic model_reset();
        m_wait   = 1'b0;
        m_halted = 1'b0;
        m_drain  = 0;
        m_cnt    = 0;
    endtask

    task automatic set_idle();
        bus.d_rs = 3'd0;  bus.d_rt = 3'd0;  bus.d_rs_vld = 1'b0;  bus.d_rt_vld = 1'b0;
        bus.dx_rd = 3'd0; bus.dx_wen = 1'b0; bus.dx_load = 1'b0;
        bus.xm_rd = 3'd0; bus.xm_wen = 1'b0; bus.xm_mem = 1'b0; bus.dmem_done = 1'b0;
        bus.imem_stall = 1'b0; bus.x_redirect = 1'b0; bus.dx_halt = 1'b0;
    endtask

    task automatic set_random(input bit allow_halt);
        bus.d_rs       = 3'($urandom_range(7));
        bus.d_rt       = 3'($urandom_range(7));
        bus.d_rs_vld   = 1'($urandom_range(1));
        bus.d_rt_vld   = 1'($urandom_range(1));
        bus.dx_rd      = 3'($urandom_range(7));
        bus.dx_wen     = 1'($urandom_range(1));
        bus.dx_load    = 1'($urandom_range(1));
        bus.xm_rd      = 3'($urandom_range(7));
        bus.xm_wen     = 1'($urandom_range(1));
        bus.xm_mem     = ($urandom_range(2) == 0);
        bus.dmem_done  = 1'($urandom_range(1));
        bus.imem_stall = ($urandom_range(4) == 0);
        bus.x_redirect = ($urandom_range(5) == 0);
        bus.dx_halt    = allow_halt && ($urandom_range(7) == 0);
    endtask

    // Entered at posedge+1 with inputs applied; returns at the next posedge+1
    task automatic do_cycle(input string tag);
        logic [7:0] e;
        logic       frz;
        #2;
        e   = model_out();
        frz = model_freeze();
        check({tag, "_out"}, 32'(obs_out), 32'(e));
        @(posedge clk);
        if (!e[7] && !m_halted && m_cnt < 15) m_cnt++;
        if (m_halted) begin
        end else if (m_drain > 0) begin
            if (m_drain == 1) m_halted = 1'b1;
            m_drain--;
        end else if (frz) begin
            m_wait = 1'b1;
        end else begin
            m_wait = 1'b0;
            if (bus.dx_halt) m_drain = 2;
        end
        #1;
        check({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        model_reset();
        #3;
        check("rst_out", 32'(obs_out), 32'h0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        do_cycle("idle");

        // Load-use: one bubble
        bus.dx_load = 1'b1; bus.dx_wen = 1'b1; bus.dx_rd = 3'd3;
        bus.d_rs = 3'd3; bus.d_rs_vld = 1'b1;
        do_cycle("lu");
        check("lu_cnt_val", 32'(bus.stall_cnt), 32'd1);

        // Non-load producer moving X -> M -> gone
        bus.dx_load = 1'b0;
        do_cycle("alu_x");
        bus.dx_wen = 1'b0; bus.xm_rd = 3'd3; bus.xm_wen = 1'b1;
        do_cycle("alu_m");
        bus.xm_wen = 1'b0;
        do_cycle("alu_gone");
`ifdef PIPE_FORWARD_EN
        check("alu_cnt_val", 32'(bus.stall_cnt), 32'd1);
`else
        check("alu_cnt_val", 32'(bus.stall_cnt), 32'd3);
`endif

        // Redirect beats a load-use match
        bus.dx_load = 1'b1; bus.dx_wen = 1'b1; bus.dx_rd = 3'd3; bus.x_redirect = 1'b1;
        do_cycle("redir_lu");
        check("redir_nops", 32'({bus.pc_en, bus.fd_nop, bus.dx_nop}), 32'h7);
        set_idle();

        // Data-memory wait of 3 cycles, then release
        bus.xm_mem = 1'b1; bus.dmem_done = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle("mwait");
        bus.dmem_done = 1'b1;
        do_cycle("mrelease");
        check("mwait_cnt_val", 32'(bus.stall_cnt), 32'(m_cnt));
        do_cycle("mhit");
        set_idle();

        for (int i = 0; i < 300; i++) begin
            set_random(1'b0);
            do_cycle("rand");
        end

        // Asynchronous reset during a memory wait
        set_idle();
        bus.xm_mem = 1'b1;
        do_cycle("mw_enter");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_out", 32'(obs_out), 32'h0);
        check("async_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        set_idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_cycle("post_rst");

        // Saturation at 2^4-1
        bus.imem_stall = 1'b1;
        for (int i = 0; i < 20; i++) do_cycle("sat");
        check("sat_val", 32'(bus.stall_cnt), 32'd15);
        set_idle();

        // Halt drain then permanent halt
        bus.dx_halt = 1'b1; bus.x_redirect = 1'b1;
        do_cycle("halt");
        for (int i = 0; i < 2; i++) begin
            set_random(1'b1);
            do_cycle("drain");
        end
        check("halted_val", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            set_random(1'b1);
            do_cycle("post_halt");
        end
        check("halt_en_val", 32'(obs_out[7:3]), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the enables and bubble/NOP-inject controls of the F/D, D/X, X/M and M/W pipeline registers and the PC register. It resolves load-use and RAW hazards, branch/jump redirects, instruction-fetch stalls, multi-cycle data-memory accesses and halt drain. It sits beside the decode stage and reads register-specifier and control bits from the D, D/X and X/M stages.

## Interface
Parameters:
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset (asserted at 0).
- d_rs / d_rt  in  3 each  source register specifiers of the instruction in D.
- d_rs_vld / d_rt_vld  in  1 each  the corresponding source is actually read.
- dx_rd  in  3  destination register of the instruction in X (D/X outputs).
- dx_wen  in  1  the instruction in X writes the register file.
- dx_load  in  1  the instruction in X is a load.
- xm_rd, xm_wen  in  3, 1  destination and write enable of the instruction in M.
- xm_mem  in  1  the instruction in M performs a data-memory access.
- dmem_done  in  1  the data memory completes the current access this cycle.
- imem_stall  in  1  the fetch has no valid instruction this cycle.
- x_redirect  in  1  a branch or jump resolved taken in X.
- dx_halt  in  1  a HALT is in X.
- pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each  register enables.
- fd_nop  out  1  load NOP (0x0800) into F/D instead of the fetched instruction.
- dx_nop  out  1  load a bubble (all control bits 0) into D/X.
- halted  out  1  the core is halted.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0, saturating.

## Operation
- States: RUN, MWAIT, DRAIN1, DRAIN2, HALTED. The state register is 3 bits wide.
- Outputs are combinational from the state and the current inputs. The rules below apply in priority order; default is all enables 1 and both NOPs 0.
  1. Memory freeze: in RUN with xm_mem=1 and dmem_done=0, or in MWAIT with dmem_done=0, all five enables are 0 and both NOPs are 0. RUN goes to MWAIT, and MWAIT stays in MWAIT. MWAIT with dmem_done=1 returns to RUN and evaluates rules 2-6 in the same cycle.
  2. Halt: dx_halt=1 in RUN gives pc_en=0, fd_en=1, fd_nop=1, dx_nop=1 and next state DRAIN1.
  3. Redirect: x_redirect=1 gives pc_en=1, fd_nop=1 and dx_nop=1. This squashes the instructions in F and D.
  4. Data hazard: a D source matches dx_rd with dx_wen=1 and dx_load=1. This gives pc_en=0, fd_en=0, dx_nop=1, and the other enables stay 1.
  5. Fetch stall: imem_stall=1 gives pc_en=0 and fd_nop=1.
  6. Otherwise, normal advance.
- DRAIN1 → DRAIN2 → HALTED, one cycle each. In these states pc_en=0, fd_en=0, dx_nop=1, and xm_en=mw_en=1.
- HALTED: all enables 0 and halted=1. Only reset exits this state.
- A register match compares the full 3-bit specifier and requires the matching _vld bit. R0 is a normal register.
- stall_cnt increments when pc_en=0 and the state is not HALTED. It holds at 2^CNT_W−1.

## Timing
- Reset (rst=0, asynchronous): state=RUN, stall_cnt=0, halted=0. All enables and NOP outputs are forced to 0 while rst=0.
- The controller adds zero latency: a decision made in cycle N takes effect at the clock edge ending cycle N.
- A load-use hazard costs exactly 1 bubble.
- A redirect costs 2 squashed slots.
- A data-memory access with done latency L costs L freeze cycles. If dmem_done=1 in the same cycle as xm_mem=1, there is no stall.
- From the dx_halt edge, halted rises 3 cycles later. Older instructions complete writeback first.
- Simultaneous events resolve by the priority above:
  - A redirect with a load-use hazard or a fetch stall means the redirect wins.
  - A halt with a redirect means the halt wins. The HALT is older than anything redirected.
  - An rst deassert mid-freeze resumes in RUN.

## Configuration
- PIPE_FORWARD_EN, defined: the X→D and M→D forwarding paths exist. Only a load-use match against X (rule 4) stalls.
- PIPE_FORWARD_EN, undefined: rule 4 also stalls on any match against X with dx_wen=1, and on any match against M with xm_wen=1. A match against X gives dx_nop=1 and pc_en=fd_en=0, repeating until the producer leaves M. The register file writes before it reads, so W needs no check.

## Test plan
- Load-use: dx_load=1, dx_rd=3, d_rs=3 with d_rs_vld=1 → one cycle with pc_en=0, fd_en=0, dx_nop=1; stall_cnt goes 0→1. Repeating the pattern with dx_load=0 → no stall when forwarding is enabled, and 2 stall cycles without it.
- Redirect: x_redirect=1 while a load-use match is present → pc_en=1, fd_nop=1, dx_nop=1, and stall_cnt is unchanged.
- Data-memory wait: xm_mem=1 with dmem_done low for 3 cycles → MWAIT for 3 cycles with all enables 0, then release on dmem_done; stall_cnt += 3. A hit (dmem_done=1 immediately) → no freeze.
- Halt: dx_halt=1 → DRAIN1, DRAIN2, then halted=1 on the 3rd edge. Afterwards all enables stay 0 for 20 cycles with random inputs.
- Reset mid-MWAIT: drive rst=0 asynchronously → outputs go to 0 without waiting for a clock and the state returns to RUN. After release with idle inputs → all enables 1.
- Saturation: with CNT_W=4, hold imem_stall for 20 cycles → stall_cnt stops at 15.
